// File: rtl/instruction_decode_stage_if.sv
// Fetch <-> decode channel: instruction and flag into ID, fetch control and
// the registered ID/EX bundle out of ID.
interface instruction_decode_stage_if #(
   parameter int INS_W  = 20,
   parameter int ADDR_W = 8,
   parameter int RIDX_W = 3
);
   logic [INS_W-1:0]  ins;
   logic              zero_flag;
   logic [ADDR_W-1:0] jmp_loc;
   logic              pc_mux_sel;
   logic              stall;
   logic              stall_pm;
   logic              ex_valid;
   logic [4:0]        ex_opcode;
   logic [RIDX_W-1:0] ex_rd;
   logic [RIDX_W-1:0] ex_rs;
   logic [7:0]        ex_imm;
   logic              halted;

   modport master (
      output ins, zero_flag,
      input  jmp_loc, pc_mux_sel, stall, stall_pm,
      input  ex_valid, ex_opcode, ex_rd, ex_rs, ex_imm, halted
   );

   modport slave (
      input  ins, zero_flag,
      output jmp_loc, pc_mux_sel, stall, stall_pm,
      output ex_valid, ex_opcode, ex_rd, ex_rs, ex_imm, halted
   );
endinterface

// File: rtl/instruction_decode_stage.sv
// Instruction decode stage: hazard detection, in-ID jump resolution,
// wrong-path squashing, halt handling and the registered ID/EX bundle.
module instruction_decode_stage #(
   parameter int INS_W  = 20,
   parameter int ADDR_W = 8,
   parameter int RIDX_W = 3
) (
   input logic                       clk,
   input logic                       reset,
   instruction_decode_stage_if.slave bus
);
   localparam logic [4:0] OP_NOP   = 5'b00000;
   localparam logic [4:0] OP_LOAD  = 5'b10100;
   localparam logic [4:0] OP_STORE = 5'b10101;
   localparam logic [4:0] OP_JMP   = 5'b11000;
   localparam logic [4:0] OP_JZ    = 5'b11001;
   localparam logic [4:0] OP_JNZ   = 5'b11010;
   localparam logic [4:0] OP_HLT   = 5'b11111;

   typedef enum logic [1:0] {RUN, STALL, FLUSH, HALT} state_t;

   state_t            state_q, state_d;
   logic              ex_valid_q, ex_valid_d;
   logic [4:0]        ex_opcode_q, ex_opcode_d;
   logic [RIDX_W-1:0] ex_rd_q, ex_rd_d;
   logic [RIDX_W-1:0] ex_rs_q, ex_rs_d;
   logic [7:0]        ex_imm_q, ex_imm_d;

   logic [INS_W-1:0]  ins;
   logic [4:0]        opcode;
   logic [RIDX_W-1:0] rd, rs;
   logic [7:0]        imm;
   logic              unused_ins_bit;
   logic              is_alu, is_load, is_store, is_jmp, is_jz, is_jnz, is_hlt;
   logic              ex_is_alu, load_use, flag_haz, hazard, taken;
   logic [ADDR_W-1:0] jmp_loc;
   logic              pc_mux_sel, stall, stall_pm;

   assign ins            = bus.ins;
   assign opcode         = ins[19:15];
   assign rd             = ins[14:12];
   assign rs             = ins[11:9];
   assign unused_ins_bit = ins[8];
   assign imm            = ins[7:0];

   assign is_alu   = (opcode != OP_NOP) && !opcode[4];
   assign is_load  = (opcode == OP_LOAD);
   assign is_store = (opcode == OP_STORE);
   assign is_jmp   = (opcode == OP_JMP);
   assign is_jz    = (opcode == OP_JZ);
   assign is_jnz   = (opcode == OP_JNZ);
   assign is_hlt   = (opcode == OP_HLT);

   // STORE reads rd as its data source, so it is checked alongside rs.
   assign ex_is_alu = ex_valid_q && (ex_opcode_q != OP_NOP) && !ex_opcode_q[4];
   assign load_use  = ex_valid_q && (ex_opcode_q == OP_LOAD) &&
                      (((is_alu || is_load || is_store) && (ex_rd_q == rs)) ||
                       (is_store && (ex_rd_q == rd)));
   assign flag_haz  = (is_jz || is_jnz) && ex_is_alu;
   assign hazard    = load_use || flag_haz;
   assign taken     = is_jmp || (is_jz && bus.zero_flag) || (is_jnz && !bus.zero_flag);

   always_comb begin
      state_d     = state_q;
      pc_mux_sel  = 1'b1;
      stall       = 1'b0;
      stall_pm    = 1'b0;
      jmp_loc     = '0;
      ex_valid_d  = 1'b0;
      ex_opcode_d = '0;
      ex_rd_d     = '0;
      ex_rs_d     = '0;
      ex_imm_d    = '0;
      if (reset) begin
         state_d = RUN;
      end else begin
         case (state_q)
            RUN, STALL: begin
               if (hazard) begin
                  stall    = 1'b1;
                  stall_pm = 1'b1;
                  state_d  = STALL;
               end else begin
                  ex_valid_d  = 1'b1;
                  ex_opcode_d = opcode;
                  ex_rd_d     = rd;
                  ex_rs_d     = rs;
                  ex_imm_d    = imm;
                  if (is_hlt) begin
                     state_d = HALT;
                  end else if (taken) begin
                     pc_mux_sel = 1'b0;
                     jmp_loc    = ADDR_W'(imm);
                     state_d    = FLUSH;
                  end else begin
                     state_d = RUN;
                  end
               end
            end
            // The instruction fetched behind a taken jump is dropped unseen.
            FLUSH: state_d = RUN;
            HALT: begin
               stall    = 1'b1;
               stall_pm = 1'b1;
            end
            default: state_d = RUN;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= RUN;
         ex_valid_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         ex_valid_q <= ex_valid_d;
      end
      ex_opcode_q <= ex_opcode_d;
      ex_rd_q     <= ex_rd_d;
      ex_rs_q     <= ex_rs_d;
      ex_imm_q    <= ex_imm_d;
   end

   assign bus.jmp_loc    = jmp_loc;
   assign bus.pc_mux_sel = pc_mux_sel;
   assign bus.stall      = stall;
   assign bus.stall_pm   = stall_pm;
   assign bus.ex_valid   = ex_valid_q;
   assign bus.ex_opcode  = ex_opcode_q;
   assign bus.ex_rd      = ex_rd_q;
   assign bus.ex_rs      = ex_rs_q;
   assign bus.ex_imm     = ex_imm_q;
   assign bus.halted     = (state_q == HALT);
endmodule

// File: tb/tb_instruction_decode_stage.sv
// Bench for instruction_decode_stage: per-cycle rows of stimulus with expected
// fetch controls; the expected ID/EX bundle is queued and checked a cycle later.
module tb_instruction_decode_stage;
   typedef struct {
      logic [19:0] ins;
      logic        zf;
      logic        rst;
      logic [11:0] ctl;   // {pc_mux_sel, stall, stall_pm, jmp_loc, halted}
      logic        v;
   } row_t;

   typedef struct {
      logic        v;
      logic        chk;
      logic [18:0] fields; // {opcode, rd, rs, imm}
   } exp_t;

   logic clk = 1'b0;
   logic reset;
   exp_t sb[$];
   int   n_tests = 0;
   int   n_fail  = 0;

   always #5 clk = ~clk;

   instruction_decode_stage_if #(.INS_W(20), .ADDR_W(8), .RIDX_W(3)) bus ();

   instruction_decode_stage #(.INS_W(20), .ADDR_W(8), .RIDX_W(3)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   function automatic row_t r(input logic [19:0] i, input logic z, input logic rs_,
                              input logic pcsel, input logic stl, input logic [7:0] jl,
                              input logic h, input logic v);
      row_t t;
      t.ins = i;
      t.zf  = z;
      t.rst = rs_;
      t.ctl = {pcsel, stl, stl, jl, h};
      t.v   = v;
      return t;
   endfunction

   task automatic apply(input row_t t);
      bus.ins       = t.ins;
      bus.zero_flag = t.zf;
      reset         = t.rst;
      @(negedge clk);
   endtask

   task automatic advance(input row_t t);
      exp_t e;
      e.v      = t.v;
      e.chk    = t.v | t.rst;
      e.fields = t.rst ? 19'd0 : {t.ins[19:9], t.ins[7:0]};
      sb.push_back(e);
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      row_t t[$];
      exp_t e;
      t.push_back(r(20'h00000, 0, 1, 1, 0, 8'h00, 0, 0));
      t.push_back(r(20'h00000, 0, 1, 1, 0, 8'h00, 0, 0));
      t.push_back(r(20'h00000, 0, 0, 1, 0, 8'h00, 0, 1));
      t.push_back(r(20'h00000, 0, 0, 1, 0, 8'h00, 0, 1));
      foreach (t[k]) begin
         apply(t[k]);
         n_tests++;
         if ({bus.pc_mux_sel, bus.stall, bus.stall_pm, bus.jmp_loc, bus.halted} !== t[k].ctl) begin
            n_fail++;
            $display("FAIL reset_ctl row %0d: got %h want %h", k,
                     {bus.pc_mux_sel, bus.stall, bus.stall_pm, bus.jmp_loc, bus.halted}, t[k].ctl);
         end
         if (sb.size() > 0) begin
            e = sb.pop_front();
            n_tests++;
            if (bus.ex_valid !== e.v || (e.chk && {bus.ex_opcode, bus.ex_rd, bus.ex_rs, bus.ex_imm} !== e.fields)) begin
               n_fail++;
               $display("FAIL reset_bundle row %0d: got v=%b f=%h want v=%b f=%h", k, bus.ex_valid,
                        {bus.ex_opcode, bus.ex_rd, bus.ex_rs, bus.ex_imm}, e.v, e.fields);
            end
         end
         advance(t[k]);
      end
   endtask

   task automatic test_load_use();
      row_t t[$];
      exp_t e;
      t.push_back(r(20'hA2000, 0, 0, 1, 0, 8'h00, 0, 1)); // LOAD r2
      t.push_back(r(20'h08400, 0, 0, 1, 1, 8'h00, 0, 0)); // ALU rs=r2 -> stall
      t.push_back(r(20'h08400, 0, 0, 1, 0, 8'h00, 0, 1));
      t.push_back(r(20'hA2000, 0, 0, 1, 0, 8'h00, 0, 1));
      t.push_back(r(20'h08600, 0, 0, 1, 0, 8'h00, 0, 1)); // rs=r3, no stall
      t.push_back(r(20'hA2000, 0, 0, 1, 0, 8'h00, 0, 1));
      t.push_back(r(20'hAA000, 0, 0, 1, 1, 8'h00, 0, 0)); // STORE rd=r2 -> stall
      t.push_back(r(20'hAA000, 0, 0, 1, 0, 8'h00, 0, 1));
      t.push_back(r(20'hA2000, 0, 0, 1, 0, 8'h00, 0, 1));
      t.push_back(r(20'h00400, 0, 0, 1, 0, 8'h00, 0, 1)); // NOP reads nothing
      t.push_back(r(20'hA2000, 0, 0, 1, 0, 8'h00, 0, 1));
      t.push_back(r(20'hA0400, 0, 0, 1, 1, 8'h00, 0, 0)); // LOAD rs=r2 -> stall
      t.push_back(r(20'hA0400, 0, 0, 1, 0, 8'h00, 0, 1));
      foreach (t[k]) begin
         apply(t[k]);
         n_tests++;
         if ({bus.pc_mux_sel, bus.stall, bus.stall_pm, bus.jmp_loc, bus.halted} !== t[k].ctl) begin
            n_fail++;
            $display("FAIL load_use_ctl row %0d: got %h want %h", k,
                     {bus.pc_mux_sel, bus.stall, bus.stall_pm, bus.jmp_loc, bus.halted}, t[k].ctl);
         end
         if (sb.size() > 0) begin
            e = sb.pop_front();
            n_tests++;
            if (bus.ex_valid !== e.v || (e.chk && {bus.ex_opcode, bus.ex_rd, bus.ex_rs, bus.ex_imm} !== e.fields)) begin
               n_fail++;
               $display("FAIL load_use_bundle row %0d: got v=%b f=%h want v=%b f=%h", k, bus.ex_valid,
                        {bus.ex_opcode, bus.ex_rd, bus.ex_rs, bus.ex_imm}, e.v, e.fields);
            end
         end
         advance(t[k]);
      end
   endtask

   task automatic test_jmp();
      row_t t[$];
      exp_t e;
      t.push_back(r(20'hC0008, 0, 0, 0, 0, 8'h08, 0, 1));
      t.push_back(r(20'h08400, 0, 0, 1, 0, 8'h00, 0, 0)); // wrong path
      t.push_back(r(20'h00000, 0, 0, 1, 0, 8'h00, 0, 1));
      foreach (t[k]) begin
         apply(t[k]);
         n_tests++;
         if ({bus.pc_mux_sel, bus.stall, bus.stall_pm, bus.jmp_loc, bus.halted} !== t[k].ctl) begin
            n_fail++;
            $display("FAIL jmp_ctl row %0d: got %h want %h", k,
                     {bus.pc_mux_sel, bus.stall, bus.stall_pm, bus.jmp_loc, bus.halted}, t[k].ctl);
         end
         if (sb.size() > 0) begin
            e = sb.pop_front();
            n_tests++;
            if (bus.ex_valid !== e.v || (e.chk && {bus.ex_opcode, bus.ex_rd, bus.ex_rs, bus.ex_imm} !== e.fields)) begin
               n_fail++;
               $display("FAIL jmp_bundle row %0d: got v=%b f=%h want v=%b f=%h", k, bus.ex_valid,
                        {bus.ex_opcode, bus.ex_rd, bus.ex_rs, bus.ex_imm}, e.v, e.fields);
            end
         end
         advance(t[k]);
      end
   endtask

   task automatic test_cond_jump();
      row_t t[$];
      exp_t e;
      t.push_back(r(20'hC8020, 0, 0, 1, 0, 8'h00, 0, 1)); // JZ, not taken
      t.push_back(r(20'hC8020, 1, 0, 0, 0, 8'h20, 0, 1)); // JZ, taken
      t.push_back(r(20'h00000, 1, 0, 1, 0, 8'h00, 0, 0));
      t.push_back(r(20'h08000, 0, 0, 1, 0, 8'h00, 0, 1)); // ALU
      t.push_back(r(20'hC8020, 1, 0, 1, 1, 8'h00, 0, 0)); // flag hazard
      t.push_back(r(20'hC8020, 1, 0, 0, 0, 8'h20, 0, 1));
      t.push_back(r(20'h00000, 0, 0, 1, 0, 8'h00, 0, 0));
      t.push_back(r(20'hD0020, 1, 0, 1, 0, 8'h00, 0, 1)); // JNZ, not taken
      t.push_back(r(20'hD0020, 0, 0, 0, 0, 8'h20, 0, 1)); // JNZ, taken
      t.push_back(r(20'h00000, 0, 0, 1, 0, 8'h00, 0, 0));
      foreach (t[k]) begin
         apply(t[k]);
         n_tests++;
         if ({bus.pc_mux_sel, bus.stall, bus.stall_pm, bus.jmp_loc, bus.halted} !== t[k].ctl) begin
            n_fail++;
            $display("FAIL cond_jump_ctl row %0d: got %h want %h", k,
                     {bus.pc_mux_sel, bus.stall, bus.stall_pm, bus.jmp_loc, bus.halted}, t[k].ctl);
         end
         if (sb.size() > 0) begin
            e = sb.pop_front();
            n_tests++;
            if (bus.ex_valid !== e.v || (e.chk && {bus.ex_opcode, bus.ex_rd, bus.ex_rs, bus.ex_imm} !== e.fields)) begin
               n_fail++;
               $display("FAIL cond_jump_bundle row %0d: got v=%b f=%h want v=%b f=%h", k, bus.ex_valid,
                        {bus.ex_opcode, bus.ex_rd, bus.ex_rs, bus.ex_imm}, e.v, e.fields);
            end
         end
         advance(t[k]);
      end
   endtask

   task automatic test_halt();
      row_t t[$];
      exp_t e;
      t.push_back(r(20'hF8000, 0, 0, 1, 0, 8'h00, 0, 1));
      for (int i = 0; i < 12; i++)
         t.push_back(r((i % 2) ? 20'hC0008 : 20'h08400, i[0], 0, 1, 1, 8'h00, 1, 0));
      t.push_back(r(20'h00000, 0, 1, 1, 0, 8'h00, 1, 0)); // reset edge still pending
      t.push_back(r(20'h00000, 0, 0, 1, 0, 8'h00, 0, 1));
      foreach (t[k]) begin
         apply(t[k]);
         n_tests++;
         if ({bus.pc_mux_sel, bus.stall, bus.stall_pm, bus.jmp_loc, bus.halted} !== t[k].ctl) begin
            n_fail++;
            $display("FAIL halt_ctl row %0d: got %h want %h", k,
                     {bus.pc_mux_sel, bus.stall, bus.stall_pm, bus.jmp_loc, bus.halted}, t[k].ctl);
         end
         if (sb.size() > 0) begin
            e = sb.pop_front();
            n_tests++;
            if (bus.ex_valid !== e.v || (e.chk && {bus.ex_opcode, bus.ex_rd, bus.ex_rs, bus.ex_imm} !== e.fields)) begin
               n_fail++;
               $display("FAIL halt_bundle row %0d: got v=%b f=%h want v=%b f=%h", k, bus.ex_valid,
                        {bus.ex_opcode, bus.ex_rd, bus.ex_rs, bus.ex_imm}, e.v, e.fields);
            end
         end
         advance(t[k]);
      end
   endtask

   task automatic test_mid_reset();
      row_t t[$];
      exp_t e;
      t.push_back(r(20'hC0008, 0, 0, 0, 0, 8'h08, 0, 1));
      t.push_back(r(20'h08400, 0, 1, 1, 0, 8'h00, 0, 0)); // reset in FLUSH
      t.push_back(r(20'h00000, 0, 0, 1, 0, 8'h00, 0, 1));
      t.push_back(r(20'hA2000, 0, 0, 1, 0, 8'h00, 0, 1));
      t.push_back(r(20'h08400, 0, 0, 1, 1, 8'h00, 0, 0));
      t.push_back(r(20'h08400, 0, 1, 1, 0, 8'h00, 0, 0)); // reset in STALL
      t.push_back(r(20'h00000, 0, 0, 1, 0, 8'h00, 0, 1));
      foreach (t[k]) begin
         apply(t[k]);
         n_tests++;
         if ({bus.pc_mux_sel, bus.stall, bus.stall_pm, bus.jmp_loc, bus.halted} !== t[k].ctl) begin
            n_fail++;
            $display("FAIL mid_reset_ctl row %0d: got %h want %h", k,
                     {bus.pc_mux_sel, bus.stall, bus.stall_pm, bus.jmp_loc, bus.halted}, t[k].ctl);
         end
         if (sb.size() > 0) begin
            e = sb.pop_front();
            n_tests++;
            if (bus.ex_valid !== e.v || (e.chk && {bus.ex_opcode, bus.ex_rd, bus.ex_rs, bus.ex_imm} !== e.fields)) begin
               n_fail++;
               $display("FAIL mid_reset_bundle row %0d: got v=%b f=%h want v=%b f=%h", k, bus.ex_valid,
                        {bus.ex_opcode, bus.ex_rd, bus.ex_rs, bus.ex_imm}, e.v, e.fields);
            end
         end
         advance(t[k]);
      end
   endtask

   task automatic test_back_to_back();
      row_t t[$];
      exp_t e;
      t.push_back(r(20'hC0008, 0, 0, 0, 0, 8'h08, 0, 1));
      t.push_back(r(20'hC0010, 0, 0, 1, 0, 8'h00, 0, 0)); // jump on wrong path ignored
      t.push_back(r(20'hC0010, 0, 0, 0, 0, 8'h10, 0, 1));
      t.push_back(r(20'hC0018, 0, 0, 1, 0, 8'h00, 0, 0));
      t.push_back(r(20'h00000, 0, 0, 1, 0, 8'h00, 0, 1));
      t.push_back(r(20'h00000, 0, 0, 1, 0, 8'h00, 0, 1));
      foreach (t[k]) begin
         apply(t[k]);
         n_tests++;
         if ({bus.pc_mux_sel, bus.stall, bus.stall_pm, bus.jmp_loc, bus.halted} !== t[k].ctl) begin
            n_fail++;
            $display("FAIL b2b_ctl row %0d: got %h want %h", k,
                     {bus.pc_mux_sel, bus.stall, bus.stall_pm, bus.jmp_loc, bus.halted}, t[k].ctl);
         end
         if (sb.size() > 0) begin
            e = sb.pop_front();
            n_tests++;
            if (bus.ex_valid !== e.v || (e.chk && {bus.ex_opcode, bus.ex_rd, bus.ex_rs, bus.ex_imm} !== e.fields)) begin
               n_fail++;
               $display("FAIL b2b_bundle row %0d: got v=%b f=%h want v=%b f=%h", k, bus.ex_valid,
                        {bus.ex_opcode, bus.ex_rd, bus.ex_rs, bus.ex_imm}, e.v, e.fields);
            end
         end
         advance(t[k]);
      end
   endtask

   initial begin
      reset         = 1'b1;
      bus.ins       = '0;
      bus.zero_flag = 1'b0;
      @(posedge clk);
      #1;
      test_reset();
      test_load_use();
      test_jmp();
      test_cond_jump();
      test_halt();
      test_mid_reset();
      test_back_to_back();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
